// File: rtl/darkbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : darkbus_pkg
// Description : Shared types and constants for the darkbus load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package darkbus_pkg;

    localparam int DARKBUS_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2,
        ILL  = 2'd3
    } lsu_size_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_ILLSIZE  = 2'd3
    } lsu_err_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    function automatic logic is_misaligned(input lsu_size_t size, input logic [1:0] ofs);
        case (size)
            HALF:    return ofs[0];
            WORD:    return |ofs;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/darkbus_if.sv
`default_nettype none
// ============================================================================
// Module      : darkbus
// Description : Darkbus signal bundle; data is driven by the producer during
//               writes, by the responder during reads, otherwise floats.
// Revision    : 1.0 - initial release
// ============================================================================
interface darkbus;
    logic        en;
    logic        rw;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] prod_data;
    logic [31:0] resp_data;
    logic        valid;
    wire  [31:0] data;

    assign data = rw ? prod_data : (en ? resp_data : 32'bz);

    modport prod (output en, output rw, output be, output addr, output prod_data,
                  input data, input valid);
    modport resp (input en, input rw, input be, input addr, input data,
                  output resp_data, output valid);
endinterface
`default_nettype wire

// File: rtl/darkbus_lane.sv
`default_nettype none
// ============================================================================
// Module      : darkbus_lane
// Description : Byte-lane steering: byte enables, store replication and
//               load extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module darkbus_lane
    import darkbus_pkg::*;
(
    input  lsu_size_t   i_size,
    input  logic [1:0]  i_ofs,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_ofs)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_ofs[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = 32'd0;
        case (i_size)
            BYTE: begin
                o_be    = 4'b0001 << i_ofs;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            HALF: begin
                o_be    = i_ofs[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            end
            WORD: begin
                o_be    = 4'b1111;
                o_rdata = i_rdata;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/darkbus_lsu.sv
`default_nettype none
// ============================================================================
// Module      : darkbus_lsu
// Description : Single-outstanding load/store initiator on the darkbus with
//               alignment checks and a programmable responder timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module darkbus_lsu
    import darkbus_pkg::*;
#(
    parameter int TIMEOUT = DARKBUS_TIMEOUT_DEFAULT
) (
    input  logic        XCLK,
    input  logic        XRES,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    darkbus.prod        BUS
);

    localparam int                 c_cnt_w    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit                 c_tmo_en   = (TIMEOUT != 0);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_t         r_state, w_next;
    lsu_size_t          r_size, w_req_size, w_ln_size;
    logic [1:0]         r_ofs, w_ln_ofs;
    logic               r_unsigned, w_ln_unsigned;
    logic               r_write;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_en, r_rw;
    logic [3:0]         r_be;
    logic [31:0]        r_addr, r_wdata;
    logic [31:0]        r_resp_rdata, w_resp_rdata;
    lsu_err_t           r_resp_err, w_resp_err;
    logic [3:0]         w_ln_be;
    logic [31:0]        w_ln_wdata, w_ln_rdata;
    logic               w_accept, w_tmo;

    assign w_req_size = lsu_size_t'(req_size);
    assign w_accept   = req_valid && (r_state == ST_IDLE);
    // Counter holds the number of completed wait cycles; the edge that would
    // make it reach TIMEOUT is the abort edge.
    assign w_tmo      = c_tmo_en && (r_cnt == c_tmo_last);

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_resp_err   = ERR_OK;
        w_resp_rdata = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_size == ILL) begin
                        w_next     = ST_RESP;
                        w_resp_err = ERR_ILLSIZE;
                    end else if (is_misaligned(w_req_size, req_addr[1:0])) begin
                        w_next     = ST_RESP;
                        w_resp_err = ERR_MISALIGN;
                    end else begin
                        w_next = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (BUS.valid) begin
                    w_next       = ST_RESP;
                    w_resp_rdata = r_write ? 32'd0 : w_ln_rdata;
                end else if (w_tmo) begin
                    w_next     = ST_RESP;
                    w_resp_err = ERR_TIMEOUT;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == ST_IDLE) && !XRES;
        resp_valid = (r_state == ST_RESP);
        // The lane steerer serves the incoming request in IDLE and the
        // registered one while the access is in flight.
        if (r_state == ST_IDLE) begin
            w_ln_size     = w_req_size;
            w_ln_ofs      = req_addr[1:0];
            w_ln_unsigned = req_unsigned;
        end else begin
            w_ln_size     = r_size;
            w_ln_ofs      = r_ofs;
            w_ln_unsigned = r_unsigned;
        end
    end

    darkbus_lane u_lane (
        .i_size     (w_ln_size),
        .i_ofs      (w_ln_ofs),
        .i_unsigned (w_ln_unsigned),
        .i_wdata    (req_wdata),
        .i_rdata    (BUS.data),
        .o_be       (w_ln_be),
        .o_wdata    (w_ln_wdata),
        .o_rdata    (w_ln_rdata)
    );

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            r_write      <= 1'b0;
            r_size       <= BYTE;
            r_ofs        <= 2'd0;
            r_unsigned   <= 1'b0;
            r_cnt        <= '0;
            r_en         <= 1'b0;
            r_rw         <= 1'b0;
            r_be         <= 4'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= ERR_OK;
        end else begin
            if (r_state == ST_IDLE && w_next == ST_ACCESS) begin
                r_write    <= req_write;
                r_size     <= w_req_size;
                r_ofs      <= req_addr[1:0];
                r_unsigned <= req_unsigned;
                r_cnt      <= '0;
                r_en       <= 1'b1;
                r_rw       <= req_write;
                r_be       <= w_ln_be;
                r_addr     <= {req_addr[31:2], 2'b00};
                r_wdata    <= w_ln_wdata;
            end else if (r_state == ST_ACCESS) begin
                if (w_next != ST_ACCESS) begin
                    r_en <= 1'b0;
                    r_rw <= 1'b0;
                end else if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_next == ST_RESP) begin
                r_resp_rdata <= w_resp_rdata;
                r_resp_err   <= w_resp_err;
            end else begin
                r_resp_rdata <= 32'd0;
                r_resp_err   <= ERR_OK;
            end
        end
    end

    assign BUS.en        = r_en;
    assign BUS.rw        = r_rw;
    assign BUS.be        = r_be;
    assign BUS.addr      = r_addr;
    assign BUS.prod_data = r_wdata;
    assign resp_rdata    = r_resp_rdata;
    assign resp_err      = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_darkbus_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_darkbus_lsu
// Description : Randomized scoreboard bench for darkbus_lsu with a
//               programmable-latency responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_darkbus_lsu;

    localparam int TMO = 4;

    typedef struct {
        logic [1:0]  err;
        logic [31:0] rdata;
        int          en_cyc;
        int          cyc;
    } exp_t;

    logic        XCLK, XRES;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    darkbus bus();

    darkbus_lsu #(.TIMEOUT(TMO)) dut (
        .XCLK         (XCLK),
        .XRES         (XRES),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .BUS          (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t sbq[$];

    logic [3:0]  exp_be = 4'd0;
    logic [31:0] exp_addr = 32'd0;
    logic        exp_rw = 1'b0;
    logic [31:0] exp_data = 32'd0;

    // Responder: raises valid after rsp_wait wait cycles unless silent
    int          rsp_cnt = 0;
    int          rsp_wait = 0;
    logic        rsp_silent = 1'b0;
    logic [31:0] rsp_word = 32'd0;

    always @(posedge XCLK) rsp_cnt <= bus.en ? rsp_cnt + 1 : 0;
    assign bus.valid     = bus.en && !rsp_silent && (rsp_cnt == rsp_wait);
    assign bus.resp_data = rsp_word;

    always @(posedge XCLK) cyc <= cyc + 1;

    initial begin
        XCLK = 1'b0;
        forever #5 XCLK = ~XCLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] ofs, input logic uns);
        logic [31:0] v;
        v = w >> (8 * ofs);
        if (sz == 2'd0) begin
            v = v & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Monitor: bus lines while en is up, and responses against the scoreboard
    int en_cnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge XCLK);
            if (XRES) begin
                en_cnt = 0;
            end else begin
                if (bus.en) begin
                    en_cnt++;
                    chk("bus_be", {28'd0, bus.be}, {28'd0, exp_be});
                    chk("bus_addr", bus.addr, exp_addr);
                    chk("bus_rw", {31'd0, bus.rw}, {31'd0, exp_rw});
                    if (exp_rw) chk("bus_wdata", bus.data, exp_data);
                end else begin
                    chk("bus_rw_idle", {31'd0, bus.rw}, 32'd0);
                end
                if (resp_valid) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got resp_valid with err %0d, expected none", resp_err);
                    end else begin
                        e = sbq.pop_front();
                        chk("resp_err", {30'd0, resp_err}, {30'd0, e.err});
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("en_cycles", en_cnt, e.en_cyc);
                        chk("resp_cycle", cyc, e.cyc);
                        chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
                    end
                    en_cnt = 0;
                end
            end
        end
    end

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int wt,
                          input logic sil, input logic [31:0] word, input bit push);
        exp_t e;
        int   n;
        n = 0;
        while (!req_ready && n < 60) begin
            @(negedge XCLK);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: got req_ready 0 after %0d cycles, expected 1", n);
            return;
        end
        rsp_wait   = wt;
        rsp_silent = sil;
        rsp_word   = word;
        e.err = 2'd0; e.rdata = 32'd0; e.en_cyc = 0;
        if (sz == 2'd3)
            e.err = 2'd3;
        else if ((sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0))
            e.err = 2'd1;
        else if (sil || wt >= TMO) begin
            e.err = 2'd2;
            e.en_cyc = TMO;
        end else begin
            e.en_cyc = wt + 1;
            if (!wr) e.rdata = model_load(word, sz, addr[1:0], uns);
        end
        case (sz)
            2'd0:    begin exp_be = 4'b0001 << addr[1:0];           exp_data = {4{wd[7:0]}};  end
            2'd1:    begin exp_be = addr[1] ? 4'b1100 : 4'b0011;    exp_data = {2{wd[15:0]}}; end
            default: begin exp_be = 4'b1111;                        exp_data = wd;            end
        endcase
        exp_addr = {addr[31:2], 2'b00};
        exp_rw   = wr;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr;  req_wdata = wd;
        @(posedge XCLK);
        #1;
        e.cyc = cyc + e.en_cyc;
        if (push) sbq.push_back(e);
        req_valid = 1'b0; req_write = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
        req_unsigned = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge XCLK);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", sbq.size());
            sbq.delete();
        end
        @(negedge XCLK);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] addr;
        XRES = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_en", {31'd0, bus.en}, 32'd0);
        chk("rst_rw", {31'd0, bus.rw}, 32'd0);
        chk("rst_be", {28'd0, bus.be}, 32'd0);
        chk("rst_addr", bus.addr, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {30'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        repeat (3) @(negedge XCLK);
        XRES = 1'b0;
        @(negedge XCLK);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0, 0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        do_req(1'b0, 2'd0, 1'b0, 32'h4000_0003, 32'd0, 0, 1'b0, 32'h80FF_FFFF, 1'b1);
        do_req(1'b0, 2'd0, 1'b1, 32'h4000_0003, 32'd0, 0, 1'b0, 32'h80FF_FFFF, 1'b1);
        do_req(1'b1, 2'd1, 1'b0, 32'h4000_0006, 32'h0000_1234, 1, 1'b0, 32'h0, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'd0, 0, 1'b0, 32'h1, 1'b1);
        do_req(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'd0, 0, 1'b0, 32'h1, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'd0, 0, 1'b1, 32'h1, 1'b1);
        do_req(1'b0, 2'd2, 1'b1, 32'h0000_0024, 32'd0, TMO - 1, 1'b0, 32'hCAFE_F00D, 1'b1);
        drain();

        // Reset in the middle of a three-wait-state access
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'd0, 3, 1'b0, 32'h1111_2222, 1'b0);
        @(negedge XCLK);
        #2 XRES = 1'b1;
        #1;
        chk("midrst_en", {31'd0, bus.en}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge XCLK);
        #1 chk("midrst_resp_valid2", {31'd0, resp_valid}, 32'd0);
        @(negedge XCLK);
        XRES = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0304, 32'd0, 0, 1'b0, 32'h5A5A_A5A5, 1'b1);
        drain();

        for (int i = 0; i < 160; i++) begin
            sz   = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = (sz == 2'd0) ? addr[1:0] : (sz == 2'd1) ? {addr[1], 1'b0} : 2'b00;
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom,
                   int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0), $urandom, 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
